// File: rtl/image_pkg.sv
// rtl/image_pkg.sv - shared types and constants for the image byte-packing path
package image_pkg;

  localparam int PIX_W = 12;
  localparam logic [7:0] HEADER_BYTE_DEFAULT  = 8'hA5;
  localparam logic [7:0] TRAILER_BYTE_DEFAULT = 8'h5A;

  typedef enum logic [2:0] {
    IDLE, HDR, GET_A, GET_B, B0, B1, B2, TRL
  } packer_state_t;

endpackage

// File: rtl/frame_byte_packer.sv
// rtl/frame_byte_packer.sv - packs 12-bit pixel pairs into a framed byte stream
module frame_byte_packer
  import image_pkg::*;
#(
  parameter int         FRAME_PIXELS = 76800,
  parameter int         CNT_W        = 17,
  parameter logic [7:0] HEADER_BYTE  = HEADER_BYTE_DEFAULT,
  parameter logic [7:0] TRAILER_BYTE = TRAILER_BYTE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_sop,
  input  logic             pix_eop,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             frame_recieved,
  output logic             frame_error
);

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_PIXELS);

  packer_state_t    state, state_nxt;
  logic [PIX_W-1:0] pa, pb, pa_nxt, pb_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             last, last_nxt;
  logic             recv_nxt, err_nxt;
  logic             pix_xfer, byte_xfer;

  assign pix_xfer  = pix_valid & pix_ready;
  assign byte_xfer = byte_valid & byte_ready;
  assign cnt_inc   = (&cnt) ? cnt : cnt + 1'b1;

  // Outputs depend only on registered state, so pix_* never reaches byte_* combinationally
  always_comb begin
    pix_ready  = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    case (state)
      IDLE, GET_A, GET_B: pix_ready = 1'b1;
      HDR: begin byte_valid = 1'b1; byte_data = HEADER_BYTE; end
      B0:  begin byte_valid = 1'b1; byte_data = pa[11:4]; end
      B1:  begin byte_valid = 1'b1; byte_data = {pa[3:0], pb[11:8]}; end
      B2:  begin byte_valid = 1'b1; byte_data = pb[7:0]; end
      TRL: begin byte_valid = 1'b1; byte_data = TRAILER_BYTE; end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    pa_nxt    = pa;
    pb_nxt    = pb;
    cnt_nxt   = cnt;
    last_nxt  = last;
    recv_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (pix_xfer && pix_sop) begin
      // A sop outside IDLE abandons the frame in flight without a trailer
      err_nxt   = (state != IDLE);
      pa_nxt    = pix_data;
      cnt_nxt   = CNT_W'(1);
      last_nxt  = pix_eop;
      if (pix_eop) pb_nxt = '0;
      state_nxt = HDR;
    end else begin
      case (state)
        HDR: if (byte_xfer) state_nxt = last ? B0 : GET_B;
        GET_A: if (pix_xfer) begin
          pa_nxt  = pix_data;
          cnt_nxt = cnt_inc;
          if (pix_eop) begin
            pb_nxt    = '0;
            last_nxt  = 1'b1;
            state_nxt = B0;
          end else begin
            state_nxt = GET_B;
          end
        end
        GET_B: if (pix_xfer) begin
          pb_nxt    = pix_data;
          cnt_nxt   = cnt_inc;
          last_nxt  = pix_eop;
          state_nxt = B0;
        end
        B0: if (byte_xfer) state_nxt = B1;
        B1: if (byte_xfer) state_nxt = B2;
        B2: if (byte_xfer) state_nxt = last ? TRL : GET_A;
        TRL: if (byte_xfer) begin
          recv_nxt  = 1'b1;
          err_nxt   = (cnt != FRAME_CNT);
          state_nxt = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      pa             <= '0;
      pb             <= '0;
      cnt            <= '0;
      last           <= 1'b0;
      frame_recieved <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      state          <= state_nxt;
      pa             <= pa_nxt;
      pb             <= pb_nxt;
      cnt            <= cnt_nxt;
      last           <= last_nxt;
      frame_recieved <= recv_nxt;
      frame_error    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_frame_byte_packer.sv
// tb/tb_frame_byte_packer.sv - scoreboard bench for frame_byte_packer
module tb_frame_byte_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] pix_data = '0;
  logic        pix_sop = 1'b0;
  logic        pix_eop = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready = 1'b1;
  logic        frame_recieved;
  logic        frame_error;

  always #5 clk = ~clk;

  frame_byte_packer #(.FRAME_PIXELS(4), .CNT_W(17)) dut (
    .clk(clk), .reset(reset),
    .pix_data(pix_data), .pix_sop(pix_sop), .pix_eop(pix_eop),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .frame_recieved(frame_recieved), .frame_error(frame_error)
  );

  logic [7:0] exp_q[$];
  logic [1:0] ev_q[$];
  int checks = 0;
  int errors = 0;
  int br_mode = 0;
  int br_phase = 0;
  logic br_manual = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_bytes(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
  endtask

  // byte_ready: 0 = always on, 1 = 1-on/2-off, 2 = manual via br_manual
  initial begin
    forever begin
      @(posedge clk); #2;
      case (br_mode)
        0: byte_ready = 1'b1;
        1: begin br_phase = (br_phase + 1) % 3; byte_ready = (br_phase == 0); end
        default: byte_ready = br_manual;
      endcase
    end
  end

  // Monitor: pops expected bytes/pulses, checks stall stability and state disjointness
  logic       stalled = 1'b0;
  logic [7:0] held = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (stalled) begin
          check("stall_valid", 32'(byte_valid), 32'd1);
          check("stall_data", 32'(byte_data), 32'(held));
        end
        if (byte_valid) check("ready_disjoint", 32'(pix_ready), 32'd0);
        if (byte_valid && byte_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL byte_unexpected actual=%0h required=none", byte_data);
          end else check("byte", 32'(byte_data), 32'(exp_q.pop_front()));
        end
        if (frame_recieved || frame_error) begin
          if (ev_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL pulse_unexpected actual=%0b%0b required=none", frame_recieved, frame_error);
          end else check("frame_pulse", 32'({frame_recieved, frame_error}), 32'(ev_q.pop_front()));
        end
      end
      stalled = byte_valid && !byte_ready && !reset;
      held    = byte_data;
    end
  end

  task automatic send_pix(input logic [11:0] d, input logic sop, input logic eop, output int waited);
    waited = 0;
    pix_data = d; pix_sop = sop; pix_eop = eop; pix_valid = 1'b1;
    @(negedge clk);
    while (!pix_ready && waited < 300) begin waited++; @(negedge clk); end
    if (!pix_ready) begin
      checks++; errors++;
      $display("FAIL pix_timeout actual=not_ready required=ready");
    end
    @(posedge clk); #1;
    pix_valid = 1'b0; pix_sop = 1'b0; pix_eop = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(posedge clk); n++; end
    repeat (4) @(posedge clk);
    #1;
    check({name, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_pulses_left"}, 32'(ev_q.size()), 32'd0);
  endtask

  task automatic frame_123(input logic [1:0] ev);
    int w;
    push_bytes(64'hA5_12_34_56_78_9A_BC_5A, 8);
    ev_q.push_back(ev);
    send_pix(12'h123, 1'b1, 1'b0, w);
    send_pix(12'h456, 1'b0, 1'b0, w);
    send_pix(12'h789, 1'b0, 1'b0, w);
    send_pix(12'hABC, 1'b0, 1'b1, w);
  endtask

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_pix_ready", 32'(pix_ready), 32'd1);
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_byte_data", 32'(byte_data), 32'd0);
    check("rst_recv", 32'(frame_recieved), 32'd0);
    check("rst_err", 32'(frame_error), 32'd0);
    @(posedge clk); #1;

    // 1: even frame, exact length
    frame_123(2'b10);
    drain("t1");

    // 2: odd frame, padded, short length
    push_bytes(64'hA5_FF_F0_00_5A_50_00_5A, 8);
    ev_q.push_back(2'b11);
    send_pix(12'hFFF, 1'b1, 1'b0, w);
    send_pix(12'h000, 1'b0, 1'b0, w);
    send_pix(12'h5A5, 1'b0, 1'b1, w);
    drain("t2");

    // 3: backpressure 1-on/2-off
    br_phase = 0;
    br_mode = 1;
    frame_123(2'b10);
    drain("t3");
    br_mode = 0;
    @(posedge clk); #1;

    // 4: pixels without sop in IDLE are dropped
    for (int i = 0; i < 10; i++) begin
      send_pix(12'(i * 12'h111), 1'b0, (i == 9), w);
      check("noise_ready_wait", 32'(w), 32'd0);
    end
    frame_123(2'b10);
    drain("t4");

    // 5: sop on the 3rd pixel aborts the frame
    push_bytes(64'hA5_11_12_22, 4);
    ev_q.push_back(2'b01);
    push_bytes(64'hA5_33_34_44_55_56_66_5A, 8);
    ev_q.push_back(2'b10);
    send_pix(12'h111, 1'b1, 1'b0, w);
    send_pix(12'h222, 1'b0, 1'b0, w);
    send_pix(12'h333, 1'b1, 1'b0, w);
    send_pix(12'h444, 1'b0, 1'b0, w);
    send_pix(12'h555, 1'b0, 1'b0, w);
    send_pix(12'h666, 1'b0, 1'b1, w);
    drain("t5");

    // 6: reset while held in B1
    br_manual = 1'b0;
    br_mode = 2;
    @(posedge clk); #1;
    push_bytes(64'hA5_AB, 2);
    send_pix(12'hABC, 1'b1, 1'b0, w);
    br_manual = 1'b1;
    @(posedge clk); #1;
    br_manual = 1'b0;
    send_pix(12'hDEF, 1'b0, 1'b1, w);
    br_manual = 1'b1;
    @(posedge clk); #1;
    br_manual = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("b1_valid", 32'(byte_valid), 32'd1);
    check("b1_data", 32'(byte_data), 32'h0CD);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst6_byte_valid", 32'(byte_valid), 32'd0);
    check("rst6_pix_ready", 32'(pix_ready), 32'd1);
    check("rst6_byte_data", 32'(byte_data), 32'd0);
    check("rst6_state", 32'(dut.state), 32'(image_pkg::IDLE));
    check("rst6_pulses", 32'({frame_recieved, frame_error}), 32'd0);
    br_mode = 0;
    @(posedge clk); #1;
    frame_123(2'b10);
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
